// File: rtl/wb_slot_scheduler_if.sv
// Issue-port bundle between the reservation station and the writeback-slot scheduler.
interface wb_slot_scheduler_if #(
  parameter int NUM_PORTS = 3
);
  logic [NUM_PORTS-1:0]   IN_reqValid;
  logic [NUM_PORTS*5-1:0] IN_reqLat;
  logic [NUM_PORTS-1:0]   IN_reqDiv;
  logic [NUM_PORTS*6-1:0] IN_reqSqN;
  logic [NUM_PORTS-1:0]   IN_stall;
  logic                   IN_invalidate;
  logic [5:0]             IN_invalidateSqN;
  logic [NUM_PORTS-1:0]   OUT_grant;
  logic                   OUT_divBusy;

  modport master (
    output IN_reqValid, IN_reqLat, IN_reqDiv, IN_reqSqN, IN_stall,
           IN_invalidate, IN_invalidateSqN,
    input  OUT_grant, OUT_divBusy
  );
  modport slave (
    input  IN_reqValid, IN_reqLat, IN_reqDiv, IN_reqSqN, IN_stall,
           IN_invalidate, IN_invalidateSqN,
    output OUT_grant, OUT_divBusy
  );
endinterface

// File: rtl/wb_slot_scheduler.sv
// Per-port result-bus reservation calendar with same-cycle issue grant.
// Define WB_SLOT_DIV_EN to add shared non-pipelined divider tracking and flush abort.
module wb_slot_scheduler #(
  parameter int NUM_PORTS = 3,
  parameter int HORIZON   = 32
) (
  input  logic clk,
  input  logic rst,
  wb_slot_scheduler_if.slave bus
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0][4:0]         lat;
  logic [NUM_PORTS-1:0]              base_ok;
  logic [NUM_PORTS-1:0]              grant;
  logic [NUM_PORTS-1:0][HORIZON-1:0] slots, slots_nxt;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign lat[p] = bus.IN_reqLat[p*5 +: 5];
    // shift-based lookup keeps out-of-range latencies from indexing past the calendar
    assign base_ok[p] = bus.IN_reqValid[p] && !bus.IN_stall[p] && !rst && !bus.IN_invalidate &&
                        (lat[p] != 5'd0) && (32'(lat[p]) < HORIZON) &&
                        ((slots[p] & (HORIZON'(1) << lat[p])) == '0);
  end

`ifdef WB_SLOT_DIV_EN
  logic [4:0]    div_cnt, div_cnt_nxt;
  logic [PW-1:0] div_port, div_sel;
  logic [5:0]    div_sqn, sqn_diff;
  logic          div_hit, abort, div_busy;

  // fixed priority: lowest-indexed eligible divide wins the idle divider
  always_comb begin
    grant   = base_ok;
    div_hit = 1'b0;
    div_sel = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (base_ok[p] && bus.IN_reqDiv[p]) begin
        if (div_cnt != 5'd0 || div_hit) grant[p] = 1'b0;
        else begin
          div_hit = 1'b1;
          div_sel = PW'(p);
        end
      end
    end
  end

  assign sqn_diff = div_sqn - bus.IN_invalidateSqN;
  assign abort    = bus.IN_invalidate && (div_cnt != 5'd0) && !sqn_diff[5] && (sqn_diff != 6'd0);

  always_comb begin
    div_cnt_nxt = div_cnt;
    if (div_hit)               div_cnt_nxt = lat[div_sel] - 5'd1;
    else if (abort)            div_cnt_nxt = 5'd0;
    else if (div_cnt != 5'd0)  div_cnt_nxt = div_cnt - 5'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= 5'd0;
      div_port <= '0;
      div_sqn  <= 6'd0;
      div_busy <= 1'b0;
    end else begin
      div_cnt  <= div_cnt_nxt;
      div_busy <= (div_cnt_nxt != 5'd0);
      if (div_hit) begin
        div_port <= div_sel;
        div_sqn  <= bus.IN_reqSqN[div_sel*6 +: 6];
      end
    end
  end

  assign bus.OUT_divBusy = div_busy;
`else
  logic unused_div_inputs;
  assign unused_div_inputs = ^{bus.IN_reqDiv, bus.IN_reqSqN, bus.IN_invalidateSqN};
  assign grant           = base_ok;
  assign bus.OUT_divBusy = 1'b0;
`endif

  assign bus.OUT_grant = grant;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++)
      slots_nxt[p] = (slots[p] >> 1) | (grant[p] ? (HORIZON'(1) << (lat[p] - 5'd1)) : '0);
`ifdef WB_SLOT_DIV_EN
    // an aborted divide frees its writeback slot, which sits at div_cnt-1 after the shift
    if (abort)
      slots_nxt[div_port] = slots_nxt[div_port] & ~(HORIZON'(1) << (div_cnt - 5'd1));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) slots <= '0;
    else     slots <= slots_nxt;
  end
endmodule

// File: tb/tb_wb_slot_scheduler.sv
// Randomized and directed bench for wb_slot_scheduler against an absolute-time reservation model.
module tb_wb_slot_scheduler;
  localparam int NP = 3;
  localparam int H  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_slot_scheduler_if #(.NUM_PORTS(NP)) bus ();
  wb_slot_scheduler_if #(.NUM_PORTS(NP)) bus16 ();

  wb_slot_scheduler #(.NUM_PORTS(NP), .HORIZON(H))  dut   (.clk(clk), .rst(rst), .bus(bus));
  wb_slot_scheduler #(.NUM_PORTS(NP), .HORIZON(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  int n_cmp  = 0;
  int n_fail = 0;

  // model: absolute cycle numbers of reserved bus cycles per port, and divider end time
  int cyc = 0;
  bit resv [NP][int];
  int div_end = 0;
  int div_port = 0;
  int div_sqn = 0;

  function automatic int req_lat(int p);
    return int'(bus.IN_reqLat[p*5 +: 5]);
  endfunction

  function automatic int req_sqn(int p);
    return int'(bus.IN_reqSqN[p*6 +: 6]);
  endfunction

  function automatic bit younger(int a, int b);
    int d;
    d = (a - b + 64) % 64;
    return (d >= 1) && (d <= 31);
  endfunction

  function automatic logic [NP-1:0] model_grant();
    logic [NP-1:0] g;
    bit claimed;
    int L;
    g = '0;
    claimed = 1'b0;
    if (rst || bus.IN_invalidate) return '0;
    for (int p = 0; p < NP; p++) begin
      L = req_lat(p);
      if (bus.IN_reqValid[p] && !bus.IN_stall[p] && L >= 1 && L <= H-1 && !resv[p].exists(cyc+L)) begin
`ifdef WB_SLOT_DIV_EN
        if (bus.IN_reqDiv[p]) begin
          if (div_end > cyc || claimed) continue;
          claimed = 1'b1;
        end
`endif
        g[p] = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic model_busy();
`ifdef WB_SLOT_DIV_EN
    return div_end > cyc;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    logic [NP-1:0] g;
    g = model_grant();
    if (rst) begin
      for (int p = 0; p < NP; p++) resv[p].delete();
      div_end = cyc;
      div_port = 0;
      div_sqn = 0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (g[p]) begin
          resv[p][cyc + req_lat(p)] = 1'b1;
`ifdef WB_SLOT_DIV_EN
          if (bus.IN_reqDiv[p]) begin
            div_end = cyc + req_lat(p);
            div_port = p;
            div_sqn = req_sqn(p);
          end
`endif
        end
      end
`ifdef WB_SLOT_DIV_EN
      if (bus.IN_invalidate && div_end > cyc && younger(div_sqn, int'(bus.IN_invalidateSqN))) begin
        resv[div_port].delete(div_end);
        div_end = cyc;
      end
`endif
    end
    cyc++;
  end

  task automatic idle();
    bus.IN_reqValid = '0; bus.IN_reqLat = '0; bus.IN_reqDiv = '0; bus.IN_reqSqN = '0;
    bus.IN_stall = '0; bus.IN_invalidate = 1'b0; bus.IN_invalidateSqN = '0;
    bus16.IN_reqValid = '0; bus16.IN_reqLat = '0; bus16.IN_reqDiv = '0; bus16.IN_reqSqN = '0;
    bus16.IN_stall = '0; bus16.IN_invalidate = 1'b0; bus16.IN_invalidateSqN = '0;
  endtask

  task automatic req(int p, int L, bit dv, int sqn);
    bus.IN_reqValid[p] = 1'b1;
    bus.IN_reqLat[p*5 +: 5] = 5'(L);
    bus.IN_reqDiv[p] = dv;
    bus.IN_reqSqN[p*6 +: 6] = 6'(sqn);
  endtask

  task automatic idle_cycles(int n);
    idle();
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [NP-1:0] exp;
    idle();
    for (int p = 0; p < NP; p++) req(p, 3, 1'b1, p);
    @(negedge clk); #2;
    exp = model_grant();
    n_cmp++;
    if (bus.OUT_grant !== exp || exp !== '0) begin
      n_fail++; $display("FAIL reset_grant got=%b want=000", bus.OUT_grant);
    end
    n_cmp++;
    if (bus.OUT_divBusy !== 1'b0) begin
      n_fail++; $display("FAIL reset_divbusy got=%b want=0", bus.OUT_divBusy);
    end
    @(negedge clk);
    rst = 1'b0;
    idle();
    @(negedge clk);
  endtask

  task automatic test_reservation();
    logic [NP-1:0] want [4];
    int lat_seq [4];
    want[0] = 3'b001; want[1] = 3'b000; want[2] = 3'b000; want[3] = 3'b001;
    lat_seq[0] = 3; lat_seq[1] = 2; lat_seq[2] = 0; lat_seq[3] = 1;
    for (int i = 0; i < 4; i++) begin
      idle();
      if (i != 2) req(0, lat_seq[i], 1'b0, 0);
      #2;
      n_cmp++;
      if (bus.OUT_grant !== want[i] || model_grant() !== want[i]) begin
        n_fail++; $display("FAIL reservation[%0d] got=%b want=%b", i, bus.OUT_grant, want[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_all_ports();
    for (int i = 0; i < 4; i++) begin
      idle();
      for (int p = 0; p < NP; p++) req(p, 1, 1'b0, 0);
      #2;
      n_cmp++;
      if (bus.OUT_grant !== 3'b111) begin
        n_fail++; $display("FAIL all_ports[%0d] got=%b want=111", i, bus.OUT_grant);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_serial();
    logic [NP-1:0] exp;
    bit p2_done;
    idle_cycles(H);
    req(1, 8, 1'b1, 7);
    #2; exp = model_grant();
    n_cmp++;
    if (bus.OUT_grant !== exp) begin
      n_fail++; $display("FAIL div_first got=%b want=%b", bus.OUT_grant, exp);
    end
    @(negedge clk);
    p2_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      idle();
      if (!p2_done) req(2, 8, 1'b1, 8);
      #2; exp = model_grant();
      n_cmp++;
      if (bus.OUT_grant !== exp) begin
        n_fail++; $display("FAIL div_serial_grant[%0d] got=%b want=%b", i, bus.OUT_grant, exp);
      end
      n_cmp++;
      if (bus.OUT_divBusy !== model_busy()) begin
        n_fail++; $display("FAIL div_serial_busy[%0d] got=%b want=%b", i, bus.OUT_divBusy, model_busy());
      end
      if (exp[2]) p2_done = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_div_priority();
    logic [NP-1:0] exp;
    idle_cycles(H);
    req(0, 5, 1'b1, 1);
    req(2, 5, 1'b1, 2);
    #2; exp = model_grant();
    n_cmp++;
    if (bus.OUT_grant !== exp) begin
      n_fail++; $display("FAIL div_priority got=%b want=%b", bus.OUT_grant, exp);
    end
    @(negedge clk);
  endtask

  task automatic inv_case(int dsqn, int isqn);
    logic [NP-1:0] exp;
    idle_cycles(H);
    req(0, 20, 1'b1, dsqn);
    #2; exp = model_grant();
    n_cmp++;
    if (bus.OUT_grant !== exp) begin
      n_fail++; $display("FAIL inv_issue[%0d/%0d] got=%b want=%b", dsqn, isqn, bus.OUT_grant, exp);
    end
    @(negedge clk);
    idle();
    req(1, 5, 1'b0, 0);
    bus.IN_invalidate = 1'b1;
    bus.IN_invalidateSqN = 6'(isqn);
    #2;
    n_cmp++;
    if (bus.OUT_grant !== 3'b000) begin
      n_fail++; $display("FAIL inv_suppress[%0d/%0d] got=%b want=000", dsqn, isqn, bus.OUT_grant);
    end
    @(negedge clk);
    idle();
    req(0, 18, 1'b0, 0);
    #2; exp = model_grant();
    n_cmp++;
    if (bus.OUT_divBusy !== model_busy()) begin
      n_fail++; $display("FAIL inv_busy[%0d/%0d] got=%b want=%b", dsqn, isqn, bus.OUT_divBusy, model_busy());
    end
    n_cmp++;
    if (bus.OUT_grant !== exp) begin
      n_fail++; $display("FAIL inv_slot[%0d/%0d] got=%b want=%b", dsqn, isqn, bus.OUT_grant, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_invalidate();
    inv_case(10, 5);
    inv_case(10, 12);
    inv_case(1, 62);
  endtask

  task automatic test_invalid_lat();
    logic [NP-1:0] want16 [4];
    int lat16 [4];
    idle_cycles(H);
    req(0, 0, 1'b0, 0);
    bus.IN_reqValid[1] = 1'b1; bus.IN_reqLat[5 +: 5] = 5'd4; bus.IN_stall[1] = 1'b1;
    #2;
    n_cmp++;
    if (bus.OUT_grant !== 3'b000) begin
      n_fail++; $display("FAIL lat0_stall got=%b want=000", bus.OUT_grant);
    end
    @(negedge clk);
    idle();
    req(1, 3, 1'b0, 0);
    #2;
    n_cmp++;
    if (bus.OUT_grant !== 3'b010) begin
      n_fail++; $display("FAIL after_stall got=%b want=010", bus.OUT_grant);
    end
    @(negedge clk);
    lat16[0] = 31; lat16[1] = 16; lat16[2] = 15; lat16[3] = 14;
    want16[0] = 3'b000; want16[1] = 3'b000; want16[2] = 3'b001; want16[3] = 3'b000;
    for (int i = 0; i < 4; i++) begin
      idle();
      bus16.IN_reqValid[0] = 1'b1;
      bus16.IN_reqLat[4:0] = 5'(lat16[i]);
      #2;
      n_cmp++;
      if (bus16.OUT_grant !== want16[i]) begin
        n_fail++; $display("FAIL h16_lat%0d got=%b want=%b", lat16[i], bus16.OUT_grant, want16[i]);
      end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_random();
    logic [NP-1:0] exp;
    for (int i = 0; i < 600; i++) begin
      idle();
      rst = ($urandom_range(0, 99) < 2);
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 1) == 1)
          req(p, int'($urandom_range(0, 31)), $urandom_range(0, 9) < 3, int'($urandom_range(0, 63)));
        bus.IN_stall[p] = ($urandom_range(0, 9) == 0);
      end
      bus.IN_invalidate = ($urandom_range(0, 19) == 0);
      bus.IN_invalidateSqN = 6'($urandom_range(0, 63));
      #2; exp = model_grant();
      n_cmp++;
      if (bus.OUT_grant !== exp) begin
        n_fail++; $display("FAIL rand_grant[%0d] got=%b want=%b", i, bus.OUT_grant, exp);
      end
      n_cmp++;
      if (bus.OUT_divBusy !== model_busy()) begin
        n_fail++; $display("FAIL rand_busy[%0d] got=%b want=%b", i, bus.OUT_divBusy, model_busy());
      end
      @(negedge clk);
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_reservation();
    test_all_ports();
    test_div_serial();
    test_div_priority();
    test_invalidate();
    test_invalid_lat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
